// File: rtl/key_entry_buffer_if.sv
// Keypad-to-decider bundle: key code strobe in, assembled frame and status strobes out.
// No backpressure: every signal is a single-cycle strobe or a level held by the buffer.
interface key_entry_buffer_if #(
    parameter int DIGITS = 4
);
    localparam int CW = $clog2(DIGITS + 1);

    logic [3:0]          Code;
    logic                Valid;
    logic [4*DIGITS-1:0] entry_data;
    logic                entry_valid;
    logic                entry_err;
    logic                timeout;
    logic [CW-1:0]       digit_count;
    logic                busy;

    modport master (
        output Code, Valid,
        input  entry_data, entry_valid, entry_err, timeout, digit_count, busy
    );

    modport slave (
        input  Code, Valid,
        output entry_data, entry_valid, entry_err, timeout, digit_count, busy
    );
endinterface

// File: rtl/key_entry_buffer.sv
// Assembles keypad digits into a DIGITS-wide frame with clear/enter keys and idle timeout.
// Strobes are registered (one cycle after the key); no backpressure, every key is processed.
module key_entry_buffer #(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input logic            clock,
    input logic            reset,
    key_entry_buffer_if.slave kif
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   buf_q, buf_n;
    logic [BW-1:0]   data_q, data_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [TW-1:0]   idle_q, idle_n;
    logic            valid_q, valid_n;
    logic            err_q, err_n;
    logic            to_q, to_n;

    logic is_digit, is_clear, is_enter;

    assign is_digit = kif.Valid && (kif.Code <= 4'd9);
    assign is_clear = kif.Valid && (kif.Code == 4'd10);
    assign is_enter = kif.Valid && (kif.Code == 4'd11);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            buf_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state   <= state_n;
            buf_q   <= buf_n;
            data_q  <= data_n;
            cnt_q   <= cnt_n;
            idle_q  <= idle_n;
            valid_q <= valid_n;
            err_q   <= err_n;
            to_q    <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        buf_n   = buf_q;
        data_n  = data_q;
        cnt_n   = cnt_q;
        idle_n  = idle_q;
        valid_n = 1'b0;
        err_n   = 1'b0;
        to_n    = 1'b0;

        if (is_digit) begin
            // A digit arriving on a full buffer is dropped but still counts as activity.
            if (state != FULL) begin
                buf_n   = (buf_q << 4) | BW'(kif.Code);
                cnt_n   = cnt_q + CW'(1);
                state_n = (cnt_n == CW'(DIGITS)) ? FULL : COLLECT;
            end
            idle_n = '0;
        end else if (is_clear || is_enter) begin
            if (is_enter) begin
                if (state == FULL) begin
                    valid_n = 1'b1;
                    data_n  = buf_q;
                end else begin
                    err_n = 1'b1;
                end
            end
            buf_n   = '0;
            cnt_n   = '0;
            idle_n  = '0;
            state_n = IDLE;
        end else if (state != IDLE) begin
            // Firing one count early makes the strobe land TIMEOUT_CYCLES after the last key.
            if (idle_q == TW'(TIMEOUT_CYCLES - 2)) begin
                to_n    = 1'b1;
                buf_n   = '0;
                cnt_n   = '0;
                idle_n  = '0;
                state_n = IDLE;
            end else begin
                idle_n = idle_q + TW'(1);
            end
        end
    end

    assign kif.entry_data  = data_q;
    assign kif.entry_valid = valid_q;
    assign kif.entry_err   = err_q;
    assign kif.timeout     = to_q;
    assign kif.digit_count = cnt_q;
    assign kif.busy        = (state != IDLE);
endmodule

// File: tb/tb_key_entry_buffer.sv
// Scoreboard bench for key_entry_buffer: a reference model predicts strobes per driven cycle,
// queues them with their due cycle, and compares every cycle against the DUT.
module tb_key_entry_buffer;
    localparam int DIGITS = 4;
    localparam int TOC    = 20;

    localparam logic [2:0] EV_NONE  = 3'b000;
    localparam logic [2:0] EV_VALID = 3'b001;
    localparam logic [2:0] EV_ERR   = 3'b010;
    localparam logic [2:0] EV_TO    = 3'b100;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    ev_t         exp_q[$];
    logic [15:0] m_buf  = '0;
    logic [15:0] m_data = '0;
    int          m_cnt  = 0;
    int          m_last = 0;

    key_entry_buffer_if #(.DIGITS(DIGITS)) kif ();

    key_entry_buffer #(
        .DIGITS(DIGITS),
        .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kif(kif)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    task automatic push_ev(input logic [2:0] kind);
        ev_t e;
        e.cyc  = cyc + 1;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Compare the DUT state produced by the previous edge against the model.
    task automatic compare_now();
        logic [2:0] want;
        logic [2:0] got;
        want = EV_NONE;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            want = exp_q[0].kind;
            void'(exp_q.pop_front());
        end
        got = {kif.timeout, kif.entry_err, kif.entry_valid};
        check_eq("strobes", 32'(got), 32'(want));
        check_eq("entry_data", 32'(kif.entry_data), 32'(m_data));
        check_eq("digit_count", 32'(kif.digit_count), 32'(m_cnt));
        check_eq("busy", 32'(kif.busy), 32'(m_cnt != 0));
    endtask

    task automatic model_clear();
        m_buf = '0;
        m_cnt = 0;
    endtask

    task automatic cycle_drive(input logic v, input logic [3:0] code);
        @(negedge clock);
        compare_now();
        reset     = 1'b0;
        kif.Valid = v;
        kif.Code  = code;
        if (v && code <= 4'd9) begin
            if (m_cnt < DIGITS) begin
                m_buf = (m_buf << 4) | 16'(code);
                m_cnt++;
            end
            m_last = cyc;
        end else if (v && code == 4'd10) begin
            model_clear();
            m_last = cyc;
        end else if (v && code == 4'd11) begin
            if (m_cnt == DIGITS) begin
                push_ev(EV_VALID);
                m_data = m_buf;
            end else begin
                push_ev(EV_ERR);
            end
            model_clear();
            m_last = cyc;
        end else if (m_cnt != 0 && cyc == m_last + TOC - 1) begin
            push_ev(EV_TO);
            model_clear();
        end
    endtask

    task automatic press(input logic [3:0] code);
        cycle_drive(1'b1, code);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_drive(1'b0, 4'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset     = 1'b1;
            kif.Valid = 1'b0;
            kif.Code  = 4'd0;
        end
        model_clear();
        m_data = '0;
        exp_q.delete();
    endtask

    task automatic press_seq(input logic [3:0] keys[$]);
        foreach (keys[i]) press(keys[i]);
    endtask

    initial begin
        kif.Valid = 1'b0;
        kif.Code  = 4'd0;
        do_reset(3);
        idle(2);

        // Full entry with an ignored code mixed in.
        press_seq('{4'd1, 4'd2, 4'd13, 4'd3, 4'd4, 4'd11});
        idle(3);

        // Short entry gives an error, frame unchanged.
        press_seq('{4'd5, 4'd6, 4'd11});
        idle(3);

        // Overflow digit discarded; then clear and re-enter.
        press_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd11});
        idle(2);
        press_seq('{4'd7, 4'd10, 4'd8, 4'd8, 4'd8, 4'd8, 4'd11});
        idle(2);

        // Partial entry times out; ignored code does not restart the counter.
        press_seq('{4'd3, 4'd3});
        idle(5);
        press(4'd13);
        idle(TOC);
        press_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd11});
        idle(2);

        // Key on the expiry cycle wins over the timeout.
        press(4'd3);
        idle(TOC - 2);
        press(4'd5);
        idle(TOC + 3);
        press(4'd11);
        idle(2);

        // Reset mid-entry abandons it silently.
        press_seq('{4'd1, 4'd2});
        do_reset(2);
        idle(2);
        press_seq('{4'd4, 4'd13, 4'd3, 4'd2, 4'd1, 4'd11});
        idle(3);

        // Back-to-back full entries with consecutive Valid.
        press_seq('{4'd9, 4'd8, 4'd7, 4'd6, 4'd11, 4'd0, 4'd0, 4'd0, 4'd1, 4'd11});
        idle(3);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
